// File: rtl/pixel_fifo_feeder_if.sv
// Upstream pixel stream into the feeder: RGB888 with valid/ready handshake and
// a start-of-frame marker qualified by in_valid.
interface pixel_fifo_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_data;
    logic        in_sof;

    modport master (output in_valid, output in_data, output in_sof, input in_ready);
    modport slave  (input in_valid, input in_data, input in_sof, output in_ready);
endinterface

// File: rtl/pixel_fifo_feeder.sv
// Show-ahead pixel FIFO that feeds the HDMI stage during DE, locks the input
// stream to the display frame at vsync and re-synchronises after underflow.
module pixel_fifo_feeder #(
    parameter int          AW          = 10,
    parameter int          PRIME_LEVEL = 512,
    parameter logic [23:0] FILL_RGB    = 24'hFF00FF
) (
    input  logic                 clock_pixel,
    input  logic                 reset,
    pixel_fifo_feeder_if.slave   pix,
    input  logic                 DE,
    input  logic                 SYNC_V,
    output logic [7:0]           oRed,
    output logic [7:0]           oGreen,
    output logic [7:0]           oBlue,
    output logic [AW:0]          level,
    output logic                 underflow,
    output logic [7:0]           resync_cnt
);
    localparam logic [1:0] SEEK  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam int            DEPTH      = 2 ** AW;
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PRIME_THR  = (AW + 1)'(PRIME_LEVEL);
    localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   level_reg, level_next;
    logic          vs_prev_reg;
    logic          underflow_reg, underflow_next;
    logic [7:0]    resync_reg, resync_next;
    logic          byp_reg;
    logic [24:0]   byp_data_reg;
    logic [24:0]   rd_q_reg;
    logic [24:0]   mem [DEPTH];

    logic        vs_edge, full, empty, accept, push, pop, flush, aligned;
    logic [24:0] head;
    logic [23:0] rgb;

    assign vs_edge = vs_prev_reg & ~SYNC_V;
    assign full    = (level_reg == FULL_LEVEL);
    assign empty   = (level_reg == '0);
    assign head    = byp_reg ? byp_data_reg : rd_q_reg;

    assign pix.in_ready = !reset && ((state_reg == SEEK) || !full);
    assign accept       = pix.in_valid && pix.in_ready;

    // An empty FIFO at vsync has no sof at its head, so it counts as misaligned.
    assign aligned = !empty && head[24];
    assign flush   = (state_reg == RUN) && vs_edge && (underflow_reg || !aligned);
    assign push    = accept && !flush && ((state_reg != SEEK) || pix.in_sof);
    assign pop     = (state_reg == RUN) && DE && !empty && !flush;

    always_comb begin
        state_next     = state_reg;
        underflow_next = underflow_reg;
        resync_next    = resync_reg;
        case (state_reg)
            SEEK: if (push) state_next = PRIME;
            PRIME: begin
                if (vs_edge && (level_reg >= PRIME_THR)) begin
                    state_next     = RUN;
                    underflow_next = 1'b0;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = SEEK;
                    if (resync_reg != 8'hFF) resync_next = resync_reg + 8'd1;
                end else if (vs_edge) begin
                    underflow_next = 1'b0;
                end else if (DE && empty) begin
                    underflow_next = 1'b1;
                end
            end
            default: state_next = SEEK;
        endcase
    end

    always_comb begin
        level_next  = level_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (reset || flush) begin
            level_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
            if (push && !pop)      level_next = level_reg + LVL_ONE;
            else if (!push && pop) level_next = level_reg - LVL_ONE;
        end
    end

    // RAM read is addressed by the next read pointer so the head is ready the
    // cycle after a pop; a write landing on that address is forwarded instead.
    always_ff @(posedge clock_pixel) begin
        if (push) mem[wr_ptr_reg] <= {pix.in_sof, pix.in_data};
        rd_q_reg <= mem[rd_ptr_next];
    end

    always_ff @(posedge clock_pixel) begin
        if (reset) begin
            state_reg     <= SEEK;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            vs_prev_reg   <= 1'b0;
            underflow_reg <= 1'b0;
            resync_reg    <= 8'd0;
            byp_reg       <= 1'b0;
            byp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            vs_prev_reg   <= SYNC_V;
            underflow_reg <= underflow_next;
            resync_reg    <= resync_next;
            byp_reg       <= push && (wr_ptr_reg == rd_ptr_next);
            byp_data_reg  <= {pix.in_sof, pix.in_data};
        end
    end

    always_comb begin
        rgb = 24'd0;
        if ((state_reg == RUN) && DE) rgb = empty ? FILL_RGB : head[23:0];
    end

    assign oRed       = rgb[23:16];
    assign oGreen     = rgb[15:8];
    assign oBlue      = rgb[7:0];
    assign level      = level_reg;
    assign underflow  = underflow_reg;
    assign resync_cnt = resync_reg;
endmodule

// File: tb/tb_pixel_fifo_feeder.sv
// Directed bench for pixel_fifo_feeder (AW=4, PRIME_LEVEL=4, 4x2 active area)
// with a scoreboard queue of pixels expected on the display side.
module tb_pixel_fifo_feeder;
    localparam int          AW   = 4;
    localparam logic [23:0] FILL = 24'hFF00FF;

    logic          clk = 1'b0;
    logic          reset;
    logic          DE;
    logic          SYNC_V;
    logic [7:0]    oRed, oGreen, oBlue;
    logic [AW:0]   level;
    logic          underflow;
    logic [7:0]    resync_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [23:0] sb [$];

    pixel_fifo_feeder_if pix ();

    pixel_fifo_feeder #(.AW(AW), .PRIME_LEVEL(4), .FILL_RGB(FILL)) dut (
        .clock_pixel (clk),
        .reset       (reset),
        .pix         (pix),
        .DE          (DE),
        .SYNC_V      (SYNC_V),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue),
        .level       (level),
        .underflow   (underflow),
        .resync_cnt  (resync_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one pixel until accepted (bounded); keep=1 queues it for display.
    task automatic send(input logic [23:0] d, input logic s, input logic keep);
        int n = 0;
        pix.in_valid = 1'b1;
        pix.in_data  = d;
        pix.in_sof   = s;
        @(negedge clk);
        while (!pix.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!pix.in_ready) check("send_timeout", {31'd0, pix.in_ready}, 32'd1);
        tick();
        pix.in_valid = 1'b0;
        if (keep && n < 50) sb.push_back(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            DE = 1'b0;
            @(negedge clk);
            check("blank_rgb", {8'd0, oRed, oGreen, oBlue}, 32'd0);
            tick();
        end
    endtask

    task automatic display_line(input int n);
        logic [23:0] exp;
        for (int i = 0; i < n; i++) begin
            DE = 1'b1;
            @(negedge clk);
            exp = (sb.size() != 0) ? sb.pop_front() : FILL;
            check("de_rgb", {8'd0, oRed, oGreen, oBlue}, {8'd0, exp});
            $display("de pixel %0d: observed %h expected %h", i, {oRed, oGreen, oBlue}, exp);
            tick();
        end
        DE = 1'b0;
    endtask

    task automatic vsync();
        SYNC_V = 1'b0;
        @(negedge clk);
        check("vsync_rgb", {8'd0, oRed, oGreen, oBlue}, 32'd0);
        tick();
        SYNC_V = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; DE = 1'b0; SYNC_V = 1'b1;
        pix.in_valid = 1'b0; pix.in_data = '0; pix.in_sof = 1'b0;

        // Reset then idle
        tick(); tick();
        @(negedge clk);
        check("reset_in_ready", {31'd0, pix.in_ready}, 32'd0);
        check("reset_rgb", {8'd0, oRed, oGreen, oBlue}, 32'd0);
        check("reset_level", {27'd0, level}, 32'd0);
        check("reset_underflow", {31'd0, underflow}, 32'd0);
        check("reset_resync", {24'd0, resync_cnt}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", {31'd0, pix.in_ready}, 32'd1);
        tick();

        // SEEK discards non-sof pixels, locks on sof, then PRIME accepts anything
        for (int i = 0; i < 3; i++) send(24'hA00000 + 24'(i), 1'b0, 1'b0);
        send(24'h112233, 1'b1, 1'b0);
        @(negedge clk);
        check("seek_lock_level", {27'd0, level}, 32'd1);
        tick();
        send(24'h445566, 1'b0, 1'b0);
        @(negedge clk);
        check("prime_accept_level", {27'd0, level}, 32'd2);
        tick();

        // Mid-frame reset discards buffered pixels
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midframe_reset_level", {27'd0, level}, 32'd0);
        check("midframe_reset_ready", {31'd0, pix.in_ready}, 32'd1);
        tick();

        // Prime and run: one 4x2 frame
        for (int i = 1; i <= 8; i++) send(24'(i), (i == 1), 1'b1);
        @(negedge clk);
        check("primed_level", {27'd0, level}, 32'd8);
        tick();
        vsync();
        idle(2);
        display_line(4);
        idle(2);
        display_line(4);
        @(negedge clk);
        check("run_underflow", {31'd0, underflow}, 32'd0);
        check("run_level", {27'd0, level}, 32'd0);
        tick();

        // Underflow: only 6 pixels for an 8-pixel frame
        for (int i = 9; i <= 14; i++) send(24'(i), (i == 9), 1'b1);
        vsync();
        idle(1);
        display_line(4);
        idle(1);
        display_line(4);
        @(negedge clk);
        check("underflow_set", {31'd0, underflow}, 32'd1);
        tick();
        send(24'h0000AA, 1'b0, 1'b0);
        send(24'h0000AB, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_flush_level", {27'd0, level}, 32'd2);
        tick();
        vsync();
        @(negedge clk);
        check("underflow_flush_level", {27'd0, level}, 32'd0);
        check("underflow_resync_cnt", {24'd0, resync_cnt}, 32'd1);
        tick();
        sb.delete();
        send(24'h0000CC, 1'b0, 1'b0);
        @(negedge clk);
        check("seek_after_flush_level", {27'd0, level}, 32'd0);
        tick();

        // Backpressure: 16 fill the FIFO, the 17th waits for the first pop
        for (int i = 0; i < 16; i++) send(24'h000100 + 24'(i), (i == 0), 1'b1);
        @(negedge clk);
        check("full_level", {27'd0, level}, 32'd16);
        check("full_in_ready", {31'd0, pix.in_ready}, 32'd0);
        tick();
        pix.in_valid = 1'b1; pix.in_data = 24'h000200; pix.in_sof = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_in_ready", {31'd0, pix.in_ready}, 32'd0);
            tick();
        end
        vsync();
        DE = 1'b1;
        @(negedge clk);
        check("bp_pop_rgb", {8'd0, oRed, oGreen, oBlue}, {8'd0, sb.pop_front()});
        check("no_write_bypass", {31'd0, pix.in_ready}, 32'd0);
        tick();
        DE = 1'b0;
        @(negedge clk);
        check("after_pop_ready", {31'd0, pix.in_ready}, 32'd1);
        check("after_pop_level", {27'd0, level}, 32'd15);
        tick();
        pix.in_valid = 1'b0;
        sb.push_back(24'h000200);
        @(negedge clk);
        check("held_accepted_level", {27'd0, level}, 32'd16);
        tick();

        // Misalignment: head has sof=0 at vsync
        vsync();
        @(negedge clk);
        check("misalign_flush_level", {27'd0, level}, 32'd0);
        check("misalign_resync_cnt", {24'd0, resync_cnt}, 32'd2);
        tick();
        sb.delete();
        send(24'h555555, 1'b0, 1'b0);
        @(negedge clk);
        check("relock_discard_level", {27'd0, level}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) send(24'h777777 + 24'(i), (i == 0), 1'b1);
        @(negedge clk);
        check("relock_level", {27'd0, level}, 32'd4);
        tick();
        vsync();
        idle(1);
        display_line(4);
        @(negedge clk);
        check("relock_underflow", {31'd0, underflow}, 32'd0);
        check("relock_resync_cnt", {24'd0, resync_cnt}, 32'd2);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
